// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one full_adder cell is time-shared across all bit
// positions, LSB first, with the carry held in a register between bits.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;

  logic w_s;
  logic w_cout;
  logic w_last;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  assign w_last = (r_cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            r_state <= StRun;
            r_a     <= a_in;
            // Subtract as a + ~b + 1: the +1 enters as the initial carry.
            r_b     <= sub ? ~b_in : b_in;
            r_carry <= sub;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= (WIDTH-1)'({w_s, r_res} >> 1);
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // r_carry here is the carry into the MSB, w_cout the carry out of it.
            sum     <= {w_s, r_res};
            cout    <= w_cout;
            ovf     <= r_carry ^ w_cout;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= StDone;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.

module tb_serial_adder_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse and wait (bounded) for done. lat counts rising edges
  // after the accept edge until done is seen; busy_cnt counts busy cycles before it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat, output int busy_cnt, output bit timeout);
    lat      = 0;
    busy_cnt = 0;
    timeout  = 1'b0;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    sub   = s;
    step();
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    sub   = 1'b0;
    while (!done) begin
      if (busy) busy_cnt++;
      if (lat >= 30) begin
        timeout = 1'b1;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a_in = '0;
    b_in = '0;
    step();
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h exp 00", sum); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout got %b exp 0", cout); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add_basic();
    int lat, bc;
    bit to;
    run_op(8'h05, 8'h03, 1'b0, lat, bc, to);
    tests++; if (to) begin fails++; $display("FAIL add_basic_timeout no done within 30 cycles"); end
    tests++; if (lat != 8) begin fails++; $display("FAIL add_basic_latency got %0d exp 8", lat); end
    tests++; if (bc != 8) begin fails++; $display("FAIL add_basic_busy_cycles got %0d exp 8", bc); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL add_basic_busy_at_done got %b exp 0", busy); end
    tests++; if (sum !== 8'h08) begin fails++; $display("FAIL add_basic_sum got %h exp 08", sum); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL add_basic_cout got %b exp 0", cout); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL add_basic_ovf got %b exp 0", ovf); end
    step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL add_basic_done_width got %b exp 0", done); end
    tests++; if (sum !== 8'h08) begin fails++; $display("FAIL add_basic_sum_hold got %h exp 08", sum); end
  endtask

  task automatic test_add_carry_ovf();
    int lat, bc;
    bit to;
    run_op(8'hFF, 8'h01, 1'b0, lat, bc, to);
    tests++; if (to) begin fails++; $display("FAIL add_carry_timeout no done"); end
    tests++; if (sum !== 8'h00) begin fails++; $display("FAIL add_carry_sum got %h exp 00", sum); end
    tests++; if (cout !== 1'b1) begin fails++; $display("FAIL add_carry_cout got %b exp 1", cout); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL add_carry_ovf got %b exp 0", ovf); end
    step();
    run_op(8'h7F, 8'h01, 1'b0, lat, bc, to);
    tests++; if (to) begin fails++; $display("FAIL add_ovf_timeout no done"); end
    tests++; if (sum !== 8'h80) begin fails++; $display("FAIL add_ovf_sum got %h exp 80", sum); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL add_ovf_cout got %b exp 0", cout); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL add_ovf_ovf got %b exp 1", ovf); end
    step();
  endtask

  task automatic test_sub();
    int lat, bc;
    bit to;
    run_op(8'h03, 8'h05, 1'b1, lat, bc, to);
    tests++; if (to) begin fails++; $display("FAIL sub_borrow_timeout no done"); end
    tests++; if (sum !== 8'hFE) begin fails++; $display("FAIL sub_borrow_sum got %h exp fe", sum); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL sub_borrow_cout got %b exp 0", cout); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL sub_borrow_ovf got %b exp 0", ovf); end
    step();
    run_op(8'h80, 8'h01, 1'b1, lat, bc, to);
    tests++; if (to) begin fails++; $display("FAIL sub_ovf_timeout no done"); end
    tests++; if (sum !== 8'h7F) begin fails++; $display("FAIL sub_ovf_sum got %h exp 7f", sum); end
    tests++; if (cout !== 1'b1) begin fails++; $display("FAIL sub_ovf_cout got %b exp 1", cout); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL sub_ovf_ovf got %b exp 1", ovf); end
    step();
  endtask

  task automatic test_start_ignored();
    int pulses = 0;
    start = 1'b1;
    a_in  = 8'h10;
    b_in  = 8'h20;
    sub   = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    step();
    // Now in RUN with counter at 3: a second request must be dropped.
    start = 1'b1;
    a_in  = 8'hAA;
    b_in  = 8'h55;
    sub   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        tests++; if (sum !== 8'h30) begin fails++; $display("FAIL ignore_sum got %h exp 30", sum); end
      end
      step();
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_abort();
    int lat, bc;
    bit to;
    int pulses = 0;
    start = 1'b1;
    a_in  = 8'h0F;
    b_in  = 8'h01;
    sub   = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done got %b exp 0", done); end
    tests++; if (sum !== 8'h00) begin fails++; $display("FAIL abort_sum got %h exp 00", sum); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL abort_cout got %b exp 0", cout); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL abort_ovf got %b exp 0", ovf); end
    for (int i = 0; i < 15; i++) begin
      if (done || busy) pulses++;
      step();
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL abort_activity got %0d exp 0", pulses); end
    run_op(8'h0F, 8'h01, 1'b0, lat, bc, to);
    tests++; if (to) begin fails++; $display("FAIL abort_restart_timeout no done"); end
    tests++; if (sum !== 8'h10) begin fails++; $display("FAIL abort_restart_sum got %h exp 10", sum); end
    tests++; if (lat != 8) begin fails++; $display("FAIL abort_restart_latency got %0d exp 8", lat); end
    step();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int bad_busy = 0;
    int last = -1;
    start = 1'b1;
    a_in  = 8'h01;
    b_in  = 8'h01;
    sub   = 1'b0;
    step();
    // Cycle i follows accept edge + i; done expected at i = 8, 17, 26.
    for (int i = 0; i < 30; i++) begin
      if (busy === done) bad_busy++;
      if (done) begin
        pulses++;
        tests++;
        if (i != ((last < 0) ? 8 : last + 9)) begin
          fails++;
          $display("FAIL b2b_done_time got %0d exp %0d", i, (last < 0) ? 8 : last + 9);
        end
        tests++; if (sum !== 8'h02) begin fails++; $display("FAIL b2b_sum got %h exp 02", sum); end
        last = i;
      end
      step();
    end
    start = 1'b0;
    tests++; if (pulses != 3) begin fails++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
    tests++; if (bad_busy != 0) begin fails++; $display("FAIL b2b_busy_gaps got %0d exp 0", bad_busy); end
    for (int i = 0; i < 12; i++) step();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_carry_ovf();
    test_sub();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller built around one instance of the team's existing 1-bit full_adder cell (ports a, b, cin, s, cout). It accepts two WIDTH-bit operands with a start/busy/done handshake. Operands are fed LSB-first through the single full adder, one bit per clock, with carry held in a register between bits. The block is the area-minimal arithmetic unit for slow control paths, where one adder cell is time-shared across all bit positions.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a_in  input  WIDTH  operand A; sampled with start
b_in  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result is valid
sum  output  WIDTH  result; held stable from done until the next accepted start
cout  output  1  final carry out (in sub mode, 1 = no borrow)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). No asynchronous logic.
- rst=1 at a rising edge forces:
  - state IDLE;
  - busy=0, done=0, sum=0, cout=0, ovf=0;
  - bit counter=0, carry register=0, operand shift registers=0.
- rst=1 mid-operation aborts the operation. No done pulse is produced, and the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN. Otherwise stay in IDLE.
  - RUN: stays for exactly WIDTH cycles (counter 0..WIDTH-1). When counter==WIDTH-1 -> DONE.
  - DONE: lasts exactly one cycle. start=1 -> RUN (back-to-back accept); otherwise -> IDLE.
- Accept (start=1 in IDLE or DONE), at that clock edge:
  - A shift register <= a_in.
  - B shift register <= b_in when sub=0, or ~b_in when sub=1.
  - carry register <= sub (two's-complement subtract via inverted B with cin=1).
  - counter <= 0; busy <= 1.
  - sum, cout and ovf are not cleared at accept; they are overwritten only at the end of the operation.
- start while in RUN is ignored. Operand and sub inputs are don't-care outside accept cycles.
- Each RUN cycle:
  - full_adder inputs are a=A[0], b=B[0], cin=carry register.
  - A and B shift right by one.
  - The s output shifts into the MSB of the internal result shift register.
  - carry register <= cout of the full adder.
  - On the cycle where counter==WIDTH-1, the carry-in to the MSB (carry register value before update) is captured for ovf.
- RUN -> DONE transition edge:
  - sum <= completed result register; cout <= final carry.
  - ovf <= carry_in_msb XOR final carry.
  - busy <= 0; done <= 1.
- Latency: start sampled at edge E0, then busy=1 during cycles E0..E(WIDTH). done=1 for the single cycle following edge E(WIDTH). A new result is available WIDTH+1 cycles after the accept edge, so throughput is one operation per WIDTH+1 cycles with back-to-back starts.
- Arithmetic: sum = (a_in ± b_in) mod 2^WIDTH. The carry out of the MSB is reported only on cout, never folded into sum.
- done and busy are never both 1. done is never asserted for two consecutive cycles unless a back-to-back operation completes (minimum spacing WIDTH+1 cycles).

Test Plan:
- WIDTH=8, a=0x05, b=0x03, sub=0, start for 1 cycle -> busy high 8 cycles; done pulses 1 cycle, 9 cycles after the accept edge; sum=0x08, cout=0, ovf=0.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- sub=1, a=0x03, b=0x05 -> sum=0xFE, cout=0 (borrow). Then sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Accept a=0x10, b=0x20; pulse start again with a=0xAA, b=0x55 at RUN cycle 3 -> second start ignored; sum=0x30; exactly one done pulse.
- Accept a=0x0F, b=0x01; assert rst at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, and no done pulse afterwards. A new start then completes normally.
- Hold start=1 continuously with a=0x01, b=0x01 -> done pulses every 9 cycles, sum=0x02 each time, and busy is low only during the done cycles.
